booth_issue_ctrl: RTL and testbench
===================================

Name: booth_issue_ctrl

Overview:
Sequencing front-end for the iterative booths_algo multiplier. Accepts signed operand pairs over a valid/ready handshake and drives the multiplier's rst/mr_in/md pins. Counts the multiplier's iteration latency, captures its product and presents it on a valid/ready result port. Lets upstream logic stream multiplications without hand-timed reset pulses.

Parameters:
N, 4, operand width (two's complement); must match the attached multiplier's N.
LAT, N+1, cycles from mul_rst deassertion until mul_out is final; LAT >= 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  controller can accept an operand pair.
in_mr  input  N  multiplier operand (signed).
in_md  input  N  multiplicand operand (signed).
mul_rst  output  1  drives multiplier rst.
mul_mr  output  N  drives multiplier mr_in.
mul_md  output  N  drives multiplier md.
mul_out  input  2N  multiplier product.
res_valid  output  1  product valid.
res_ready  input  1  downstream accepts product.
res_data  output  2N  signed product.
busy  output  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, LOAD, RUN, DONE; state register plus counter cnt of width clog2(LAT)+1.
- Reset (rst high at an edge), from any state including mid-RUN or DONE:
  - state=IDLE, cnt=0, operand regs=0, res_data=0, res_valid=0.
  - In-flight product is discarded; no partial result is ever presented.
- Outputs by state:
  - in_ready = (state==IDLE) && !rst; purely state-decoded, no combinational path from res_ready.
  - mul_rst = 1 in IDLE and LOAD, 0 in RUN and DONE.
  - mul_mr/mul_md are always the registered operands, held stable from LOAD through DONE.
- IDLE: on in_valid && in_ready at edge k, latch in_mr/in_md and go to LOAD.
- LOAD: occupies cycle k+1 with mul_rst=1 and new operands on the pins. Set cnt=LAT-1, go to RUN.
- RUN: mul_rst=0.
  - If cnt!=0, cnt decrements each edge.
  - At the edge where cnt==0, capture res_data<=mul_out, set res_valid=1, go to DONE.
- Timing: res_valid first high in cycle k+2+LAT (k+7 for N=4, LAT=5); mul_out is sampled exactly once.
- DONE: res_valid and res_data hold unchanged while res_ready is low.
  - On res_valid && res_ready: clear res_valid, go to IDLE. in_ready rises in the following cycle.
- Throughput: one product per LAT+3 cycles; no overlap of issue and drain.
- in_valid while not in_ready is ignored and has no side effect; upstream must hold operands.
- res_data is the full 2N-bit two's-complement product; no truncation or saturation.
  - Corner case: (-2^(N-1))*(-2^(N-1)) = +2^(2N-2) must appear correctly.
- Simultaneous rst and handshake: rst wins.

Decomposition:
- Shared package booth_pkg holds the state enum (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3) and the default-LAT function N+1, reused by other booth stages.
- No sub-module: single flat FSM plus datapath registers.
- booths_algo is instantiated alongside by the parent, not inside this block.

Test Plan:
- Bench wiring: connect an instance of booths_algo (N=4) to the mul_* pins.
- in_mr=7, in_md=5, res_ready=1 -> res_valid high exactly 7 cycles after accept, res_data=8'h23; busy low the cycle after drain.
- in_mr=3, in_md=-5 (4'b1011) -> res_data=8'hF1 (-15).
- in_mr=-8, in_md=-8 -> res_data=8'h40; in_mr=-8, in_md=7 -> res_data=8'hC8.
- Backpressure: hold res_ready=0 for 4 cycles after res_valid -> res_data stable, in_ready=0, second in_valid ignored. Raise res_ready -> one transfer, then the second pair is accepted.
- Assert rst for 1 cycle during RUN (cnt=2) -> next cycle IDLE, res_valid=0, res_data=0, mul_rst=1, no result emitted. New pair 2*3 then yields 8'h06.
- Back-to-back: 8 random signed pairs with res_ready=1 -> each result equals the signed reference product, spaced LAT+3 cycles.

Source files
------------

// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_pkg
// Description : Shared definitions for the booth multiplier pipeline stages:
//               issue-controller state encoding and default latency helper.
// Revision    : 1.0  initial release
// ============================================================================
package booth_pkg;

  // Issue controller states; encoding is fixed so other stages can decode it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Iterative booths_algo needs one setup step plus one step per operand bit.
  function automatic int default_lat(input int n);
    return n + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : booth_issue_ctrl_if
// Description : Operand and result valid/ready channels of the booth issue
//               controller. master = upstream/downstream side, slave = ctrl.
// Revision    : 1.0  initial release
// ============================================================================
interface booth_issue_ctrl_if #(
  parameter int N = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_mr;
  logic [N-1:0]     in_md;
  logic             res_valid;
  logic             res_ready;
  logic [2*N-1:0]   res_data;

  modport master (
    output in_valid, in_mr, in_md, res_ready,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_mr, in_md, res_ready,
    output in_ready, res_valid, res_data
  );

endinterface
`default_nettype wire

// File: rtl/booth_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : booth_issue_ctrl
// Description : Sequencing front-end for the iterative booths_algo multiplier.
//               Accepts an operand pair, holds the multiplier in reset for one
//               load cycle, waits LAT cycles, captures the product once and
//               presents it on a valid/ready result port.
// Revision    : 1.0  initial release
// ============================================================================
module booth_issue_ctrl
  import booth_pkg::*;
#(
  parameter int N   = 4,
  parameter int LAT = default_lat(N)
) (
  input  logic             clk,
  input  logic             rst,
  booth_issue_ctrl_if.slave bus,
  output logic             mul_rst,
  output logic [N-1:0]     mul_mr,
  output logic [N-1:0]     mul_md,
  input  logic [2*N-1:0]   mul_out,
  output logic             busy
);

  localparam int CW = $clog2(LAT) + 1;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    op_mr;
  logic [N-1:0]    op_md;
  logic [2*N-1:0]  res_data;
  logic            res_valid;

  // Accept only from IDLE; reset blocks acceptance in the same cycle so a
  // simultaneous handshake can never be half-taken.
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data;

  // Multiplier is held in reset until the operands have been on its pins for
  // a full cycle (LOAD), then released for the iteration window.
  assign mul_rst = (state == IDLE) || (state == LOAD);
  assign mul_mr  = op_mr;
  assign mul_md  = op_md;
  assign busy    = (state != IDLE);

  // Issue/wait/drain sequencer with operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_mr     <= '0;
      op_md     <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_mr <= bus.in_mr;
            op_md <= bus.in_md;
            state <= LOAD;
          end
        end
        LOAD: begin
          cnt   <= CW'(LAT - 1);
          state <= RUN;
        end
        RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            // Product is final only now; sample it exactly once.
            res_data  <= mul_out;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_issue_ctrl
// Description : Directed bench for booth_issue_ctrl with a behavioural
//               radix-2 Booth multiplier (N=4) attached to the mul_* pins.
// Revision    : 1.0  initial release
// ============================================================================
module tb_booth_issue_ctrl;

  localparam int N = 4;

  logic          clk;
  logic          rst;
  logic          mul_rst;
  logic [N-1:0]  mul_mr;
  logic [N-1:0]  mul_md;
  logic [2*N-1:0] mul_out;
  logic          busy;

  int checks;
  int failures;
  int cyc;
  int lat;
  int t_res;
  int t_prev;
  logic seen;

  booth_issue_ctrl_if #(.N(N)) bus ();

  booth_issue_ctrl #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .mul_rst (mul_rst),
    .mul_mr  (mul_mr),
    .mul_md  (mul_md),
    .mul_out (mul_out),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural iterative Booth multiplier: loads on rst, one step per edge.
  logic signed [N:0] ma, mm, a_n;
  logic [N-1:0]      mq;
  logic              mq1;
  int                mi;

  always_comb begin
    a_n = ma;
    case ({mq[0], mq1})
      2'b01:   a_n = ma + mm;
      2'b10:   a_n = ma - mm;
      default: a_n = ma;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mul_rst) begin
      ma  <= '0;
      mm  <= {mul_md[N-1], mul_md};
      mq  <= mul_mr;
      mq1 <= 1'b0;
      mi  <= 0;
    end else if (mi < N) begin
      ma  <= {a_n[N], a_n[N:1]};
      mq  <= {a_n[0], mq[N-1:1]};
      mq1 <= mq[0];
      mi  <= mi + 1;
    end
  end

  assign mul_out = {ma[N-1:0], mq};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for res_valid; lat counts cycles since the accept edge.
  task automatic wait_result(input int start);
    lat = start;
    while (!bus.res_valid && lat < 40) begin
      step();
      lat++;
    end
    t_res = cyc;
  endtask

  // One full transaction with res_ready held high.
  task automatic run(input logic [N-1:0] mr, input logic [N-1:0] md,
                     input logic [2*N-1:0] exp, input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_mr    = mr;
    bus.in_md    = md;
    step();
    bus.in_valid = 1'b0;
    wait_result(1);
    chk({tag, "_latency"}, 64'(lat), 64'd7);
    chk({tag, "_data"}, 64'(bus.res_data), 64'(exp));
    step();
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic signed [N-1:0]   ra, rb;
    logic signed [2*N-1:0] re;

    checks       = 0;
    failures     = 0;
    cyc          = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_mr    = '0;
    bus.in_md    = '0;
    bus.res_ready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_mul_rst", 64'(mul_rst), 64'd1);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_res_data", 64'(bus.res_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // Basic products
    run(4'd7, 4'd5, 8'h23, "p7x5");
    run(4'd3, 4'b1011, 8'hF1, "p3xm5");
    run(4'b1000, 4'b1000, 8'h40, "pm8xm8");
    run(4'b1000, 4'd7, 8'hC8, "pm8x7");

    // Backpressure: 2*-3 held while a second pair 6*-7 waits
    bus.res_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mr     = 4'd2;
    bus.in_md     = 4'b1101;
    step();
    bus.in_mr     = 4'd6;
    bus.in_md     = 4'b1001;
    wait_result(1);
    chk("bp_latency", 64'(lat), 64'd7);
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid_hold", 64'(bus.res_valid), 64'd1);
      chk("bp_data_hold", 64'(bus.res_data), 64'hFA);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_mul_mr", 64'(mul_mr), 64'd2);
      step();
    end
    bus.res_ready = 1'b1;
    step();
    chk("bp_drained", 64'(bus.res_valid), 64'd0);
    chk("bp_idle_ready", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_second_busy", 64'(busy), 64'd1);
    chk("bp_second_mr", 64'(mul_mr), 64'd6);
    wait_result(1);
    chk("bp_second_latency", 64'(lat), 64'd7);
    chk("bp_second_data", 64'(bus.res_data), 64'hD6);
    step();

    // Reset mid-RUN (cnt==2): result discarded
    bus.in_valid = 1'b1;
    bus.in_mr    = 4'd5;
    bus.in_md    = 4'd5;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    chk("midrun_mul_rst_low", 64'(mul_rst), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrun_busy", 64'(busy), 64'd0);
    chk("midrun_res_valid", 64'(bus.res_valid), 64'd0);
    chk("midrun_res_data", 64'(bus.res_data), 64'd0);
    chk("midrun_mul_rst", 64'(mul_rst), 64'd1);
    chk("midrun_mul_mr", 64'(mul_mr), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.res_valid) seen = 1'b1;
      step();
    end
    chk("midrun_no_result", 64'(seen), 64'd0);
    run(4'd2, 4'd3, 8'h06, "after_rst");

    // Back-to-back random pairs, spacing LAT+3 between results
    t_prev = -1;
    for (int i = 0; i < 8; i++) begin
      ra = N'($urandom_range(0, 15));
      rb = N'($urandom_range(0, 15));
      re = ra * rb;
      run(ra, rb, re, "rand");
      if (t_prev >= 0) chk("rand_spacing", 64'(t_res - t_prev), 64'd8);
      t_prev = t_res;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
